tdc_stimulus_gen: RTL



---
 rtl/tdc_stimulus_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tdc_stimulus_gen.sv
// START/STOP pulse-pair generator: rising edges separated by an exact cycle count,
// repeated as a burst with a fixed idle gap between pairs.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a configuration; outputs low
// RUN   | timeline t drives START over [0,W'-1] and STOP over [D,D+W'-1]
// HOLD  | outputs low for HOLDOFF cycles, then next pair or burst end
module tdc_stimulus_gen #(
   parameter int DLY_W   = 8,
   parameter int PW_W    = 4,
   parameter int CNT_W   = 8,
   parameter int HOLDOFF = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [DLY_W-1:0] cfg_delay,
   input  logic [PW_W-1:0]  cfg_width,
   input  logic [CNT_W-1:0] cfg_count,
   output logic             start_o,
   output logic             stop_o,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pairs_sent
);

   // one extra bit over the wider code so D+W'-1 never wraps
   localparam int T_W = ((DLY_W > PW_W) ? DLY_W : PW_W) + 1;
   localparam int H_W = $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

   state_t           state, state_nxt;
   logic [DLY_W-1:0] d_r, d_nxt;
   logic [PW_W-1:0]  w_r, w_nxt;
   logic [CNT_W-1:0] n_r, n_nxt;
   logic [T_W-1:0]   t_r, t_nxt;
   logic [H_W-1:0]   hold_cnt, hold_nxt;
   logic [CNT_W-1:0] pairs_nxt;
   logic             start_nxt, stop_nxt, done_nxt;
   logic [T_W-1:0]   t_last;
   logic             accept;

   assign cfg_ready = (state == S_IDLE) && ena && rst_n;
   assign busy      = (state != S_IDLE);
   assign accept    = cfg_valid && cfg_ready;
   assign t_last    = T_W'(d_r) + T_W'(w_r) - T_W'(1);

   always_comb begin
      state_nxt = state;
      d_nxt     = d_r;
      w_nxt     = w_r;
      n_nxt     = n_r;
      t_nxt     = t_r;
      hold_nxt  = hold_cnt;
      pairs_nxt = pairs_sent;
      start_nxt = 1'b0;
      stop_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               d_nxt     = cfg_delay;
               w_nxt     = (cfg_width == '0) ? PW_W'(1) : cfg_width;
               n_nxt     = (cfg_count == '0) ? CNT_W'(1) : cfg_count;
               pairs_nxt = '0;
               t_nxt     = '0;
               start_nxt = 1'b1;
               stop_nxt  = (cfg_delay == '0);
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!ena) begin
               state_nxt = S_IDLE;
            end else if (t_r == t_last) begin
               pairs_nxt = pairs_sent + CNT_W'(1);
               hold_nxt  = H_W'(HOLDOFF - 1);
               state_nxt = S_HOLD;
            end else begin
               t_nxt     = t_r + T_W'(1);
               start_nxt = (t_nxt < T_W'(w_r));
               stop_nxt  = (t_nxt >= T_W'(d_r)) && (t_nxt <= t_last);
            end
         end
         S_HOLD: begin
            if (!ena) begin
               state_nxt = S_IDLE;
            end else if (hold_cnt == '0) begin
               if (pairs_sent == n_r) begin
                  done_nxt  = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  t_nxt     = '0;
                  start_nxt = 1'b1;
                  stop_nxt  = (d_r == '0);
                  state_nxt = S_RUN;
               end
            end else begin
               hold_nxt = hold_cnt - H_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         d_r        <= '0;
         w_r        <= '0;
         n_r        <= '0;
         t_r        <= '0;
         hold_cnt   <= '0;
         pairs_sent <= '0;
         start_o    <= 1'b0;
         stop_o     <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         d_r        <= d_nxt;
         w_r        <= w_nxt;
         n_r        <= n_nxt;
         t_r        <= t_nxt;
         hold_cnt   <= hold_nxt;
         pairs_sent <= pairs_nxt;
         start_o    <= start_nxt;
         stop_o     <= stop_nxt;
         done       <= done_nxt;
      end
   end

endmodule
